// File: rtl/inst_issuer.sv
// Systolic-array instruction sequencer: buffers macro-commands in a small FIFO and
// expands each into a per-cycle stream of {opcode, address, operand} instructions.
module inst_issuer #(
    parameter int unsigned OPCODE_BITS  = 4,
    parameter int unsigned ADDR_BITS    = 8,
    parameter int unsigned OPERAND_BITS = 128,
    parameter int unsigned FIFO_DEPTH   = 4,
    localparam int unsigned INST_BITS   = OPCODE_BITS + ADDR_BITS + OPERAND_BITS
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [OPCODE_BITS-1:0]  cmd_opcode,
    input  logic [ADDR_BITS-1:0]    cmd_addr,
    input  logic [ADDR_BITS-1:0]    cmd_len,
    input  logic                    data_valid,
    output logic                    data_ready,
    input  logic [OPERAND_BITS-1:0] data_in,
    output logic [INST_BITS-1:0]    instruction,
    output logic                    busy,
    output logic                    done,
    output logic                    err_illegal
);

    localparam int unsigned PtrBits  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CmdBits  = OPCODE_BITS + 2 * ADDR_BITS;
    localparam int unsigned CntBits  = PtrBits + 1;

    localparam logic [OPCODE_BITS-1:0] OpFirst       = OPCODE_BITS'(1);
    localparam logic [OPCODE_BITS-1:0] OpLast        = OPCODE_BITS'(8);
    localparam logic [OPCODE_BITS-1:0] OpWriteData   = OPCODE_BITS'(5);
    localparam logic [OPCODE_BITS-1:0] OpWriteWeight = OPCODE_BITS'(6);

    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    // Command FIFO
    logic [CmdBits-1:0] mem_q [FIFO_DEPTH];
    logic [PtrBits-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntBits-1:0] count_q;
    logic               fifo_full, fifo_empty, push, pop;

    logic [OPCODE_BITS-1:0] head_op;
    logic [ADDR_BITS-1:0]   head_addr, head_len;
    logic                   head_legal;

    assign fifo_full  = (count_q == CntBits'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;

    assign {head_op, head_addr, head_len} = mem_q[rd_ptr_q];
    assign head_legal = (head_op >= OpFirst) && (head_op <= OpLast);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_opcode, cmd_addr, cmd_len};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PtrBits'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PtrBits'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrBits'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PtrBits'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CntBits'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CntBits'(1);
            end
        end
    end

    // Sequencer
    state_e                  state_q, state_d;
    logic [OPCODE_BITS-1:0]  op_q, op_d;
    logic [ADDR_BITS-1:0]    base_q, base_d, len_q, len_d, beat_q, beat_d;
    logic [INST_BITS-1:0]    inst_q, inst_d;
    logic                    done_q, done_d, err_q, err_d;

    logic                    cur_is_write, beat_fire, load_head;
    logic [ADDR_BITS-1:0]    beat_addr;
    logic [OPERAND_BITS-1:0] operand;

    assign cur_is_write = (op_q == OpWriteData) || (op_q == OpWriteWeight);
    assign beat_fire    = !cur_is_write || data_valid;
    assign beat_addr    = base_q + beat_q;
    assign operand      = cur_is_write ? data_in : '0;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        base_d     = base_q;
        len_d      = len_q;
        beat_d     = beat_q;
        inst_d     = '0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        pop        = 1'b0;
        load_head  = 1'b0;
        data_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_legal) begin
                        load_head = 1'b1;
                        state_d   = StIssue;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StIssue: begin
                data_ready = cur_is_write;
                if (beat_fire) begin
                    inst_d = {op_q, beat_addr, operand};
                    if (beat_q == len_q) begin
                        done_d = 1'b1;
                        // Chain straight into the next queued command to avoid a bubble.
                        if (!fifo_empty) begin
                            pop = 1'b1;
                            if (head_legal) begin
                                load_head = 1'b1;
                            end else begin
                                err_d   = 1'b1;
                                state_d = StIdle;
                            end
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        beat_d = beat_q + ADDR_BITS'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (load_head) begin
            op_d   = head_op;
            base_d = head_addr;
            len_d  = head_len;
            beat_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            base_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            inst_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            base_q  <= base_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            inst_q  <= inst_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign instruction = inst_q;
    assign done        = done_q;
    assign err_illegal = err_q;
    assign busy        = (state_q == StIssue) || !fifo_empty;

endmodule

// File: doc/inst_issuer.md
Name: inst_issuer

Overview:
- Instruction sequencer: the initiator side of the systolic-array instruction port.
- Accepts compact macro-commands (opcode, base address, beat count) over a valid/ready interface and buffers them in a small FIFO.
- Expands each command into a per-cycle stream of 140-bit instructions driven straight into SYSTOLIC_ARRAY.instruction.
- For WRITE_DATA/WRITE_WEIGHT commands, pulls one 128-bit operand per beat from a separate data stream; emits IDLE instructions whenever there is no work.

Parameters:
- OPCODE_BITS, 4, opcode field width
- ADDR_BITS, 8, buffer address field width
- OPERAND_BITS, 128, operand field width (16 x 8-bit lanes)
- FIFO_DEPTH, 4, command FIFO entries (power of 2)
- INST_BITS, OPCODE_BITS+ADDR_BITS+OPERAND_BITS (140), derived; do not override

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command FIFO can accept
- cmd_opcode  in  OPCODE_BITS  instruction opcode (0x1..0x8 legal)
- cmd_addr  in  ADDR_BITS  base address
- cmd_len  in  ADDR_BITS  beats minus 1 (0 = 1 beat, 255 = 256 beats)
- data_valid  in  1  write operand available
- data_ready  out  1  issuer consumes operand this cycle if data_valid
- data_in  in  OPERAND_BITS  write operand
- instruction  out  INST_BITS  {opcode[139:136], addr[135:128], operand[127:0]}, registered
- busy  out  1  FIFO non-empty or issuing
- done  out  1  one-cycle pulse with the last instruction of a command
- err_illegal  out  1  one-cycle pulse when an illegal opcode is dropped

Behaviour:
- Reset (async, immediate): instruction=0 (IDLE_INST), done=0, err_illegal=0, FIFO empty, state=S_IDLE, beat counter=0. cmd_ready is high after release. Reset mid-command discards all queued and in-flight work.
- cmd_ready = !fifo_full. Push occurs on cmd_valid&&cmd_ready. There is no pass-through when full, even if a pop happens in the same cycle.
- Illegal opcodes (0x0, 0x9..0xF) are popped and dropped. err_illegal pulses on the pop edge; no instructions are issued and the next entry is examined on the following cycle.
- FSM:
  - S_IDLE: if the FIFO is non-empty, pop the head into current registers (op, base, len), set beat=0, go to S_ISSUE. instruction=0 while in S_IDLE.
  - S_ISSUE: on each edge where a beat fires, instruction <= {op, base+beat (mod 2^ADDR_BITS), operand}.
  - A beat always fires for non-write ops; their operand is 0.
  - For WRITE_DATA (0x5) / WRITE_WEIGHT (0x6): data_ready=1 throughout S_ISSUE. A beat fires only when data_valid, with operand=data_in. Otherwise instruction <= 0 (bubble) and beat holds.
  - data_ready=0 in S_IDLE and for non-write ops.
  - On the edge firing beat==len: done<=1. If the FIFO is non-empty, pop the next command directly with no bubble, staying in S_ISSUE with beat=0; else go to S_IDLE.
- Latency: command accepted at edge E0 into an empty, idle issuer → first instruction visible after edge E0+2. Back-to-back queued commands issue with zero gap.
- Address wraps modulo 256; len=255 issues 256 beats.
- busy = (state==S_ISSUE) || !fifo_empty.
- done and err_illegal are registered, high for exactly one cycle.
- Push and pop in the same cycle: FIFO count unchanged; ordering strictly FIFO.

Test Plan:
- Push WRITE_DATA addr=0x00 len=3, data_valid=1, data_in=k per beat → instruction 0x5/00..03 with operands 0..3 on 4 consecutive cycles (first at accept+2), done on the 4th, then instruction=0.
- Same as above with data_valid low on beat 2 for 2 cycles → two all-zero bubbles, address holds at 0x02, no beat skipped, done on the last beat.
- Queue LOAD_DATA addr=0 len=3, then LOAD_WEIGHT addr=0 len=3 → 8 contiguous instructions (0x1/00..03, 0x2/00..03), operand 0, done pulses on cycles 4 and 8, data_ready stays 0.
- MAT_MUL addr=0xFE len=3 → addresses FE, FF, 00, 01.
- Stall the issuer with a 256-beat write and data_valid=0, push 4 commands → cmd_ready=0 after the 4th. Push opcode 0xF → err_illegal pulse, no instructions for it.
- Assert reset_n=0 mid-command → instruction=0 and busy=0 immediately. After release, cmd_ready=1 and a new command issues normally.
